seg_msg_sequencer: RTL

SEG_MSG_SEQUENCER -- requirements
Module: seg_msg_sequencer

---
 rtl/seg_msg_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg_msg_sequencer.sv
// Plays a stored message of 7-seg character codes: each character is shown for
// HOLD_TICKS display ticks, then blanked for one tick; optional looping and pause.
module seg_msg_sequencer #(
  parameter int TICK_DIV   = 2,
  parameter int HOLD_TICKS = 3
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic [4:0] msg_len,
  input  logic       start,
  input  logic       loop,
  input  logic       pause,
  output logic [5:0] code,
  output logic       code_valid,
  output logic [3:0] idx,
  output logic       busy,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      mem_q [16];
  logic [5:0]      code_q, code_d;
  logic [3:0]      idx_q, idx_d;
  logic [4:0]      len_q, len_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            tick, last_hold, last_char;

  // Message memory has no reset so its contents survive a playback abort.
  always_ff @(posedge clk_2) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign last_hold = (hold_q == HW'(HOLD_TICKS - 1));
  assign last_char = ({1'b0, idx_q} == (len_q - 5'd1));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    len_d   = len_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (start && (msg_len != 5'd0)) begin
          len_d   = (msg_len > 5'd16) ? 5'd16 : msg_len;
          idx_d   = 4'd0;
          code_d  = mem_q[0];
          presc_d = '0;
          hold_d  = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (!pause) begin
          if (tick) begin
            presc_d = '0;
            if (last_hold) begin
              hold_d  = '0;
              state_d = GAP;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      GAP: begin
        if (!pause) begin
          if (tick) begin
            presc_d = '0;
            // Code is only reloaded here, so writes to the shown slot wait for the next visit.
            if (!last_char) begin
              idx_d   = idx_q + 4'd1;
              code_d  = mem_q[idx_q + 4'd1];
              state_d = SHOW;
            end else if (loop) begin
              idx_d   = 4'd0;
              code_d  = mem_q[0];
              state_d = SHOW;
            end else begin
              state_d = DONE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= 6'd0;
      idx_q   <= 4'd0;
      len_q   <= 5'd0;
      presc_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
    end
  end

  assign code       = code_q;
  assign code_valid = (state_q == SHOW);
  assign idx        = idx_q;
  assign busy       = (state_q == SHOW) || (state_q == GAP);
  assign done       = (state_q == DONE);

endmodule
